// File: rtl/pullup_bus_sched.sv
// Round-robin scheduler for a shared open-drain line held high by a pullup.
// Serializes the granted word MSB-first, reads the line back for collisions, then settles.
module pullup_bus_sched #(
  parameter int NREQ          = 4,
  parameter int WIDTH         = 8,
  parameter int BIT_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data_in,
  input  logic                    line_in,
  output logic                    od_oe,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic                    err,
  output logic [WIDTH-1:0]        rx_data
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE} state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     winner;
  logic [PW-1:0]     idx;
  logic              found;
  logic [WIDTH-1:0]  sel_word;
  logic [WIDTH-1:0]  shreg;
  logic [CW-1:0]     cyc;
  logic [BW-1:0]     bitn;
  logic [SW-1:0]     scnt;
  logic              sample;
  logic              collide;

  assign sample  = (cyc == CW'(BIT_CYCLES - 1));
  // A released line that reads low means another device is pulling it.
  assign collide = ~od_oe & ~line_in;

  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (PW'(k) == winner) sel_word = data_in[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      od_oe   <= 1'b0;
      gnt     <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rx_data <= '0;
      rr_ptr  <= '0;
      shreg   <= '0;
      cyc     <= '0;
      bitn    <= '0;
      scnt    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          od_oe <= 1'b0;
          if (found) begin
            gnt    <= NREQ'(1) << winner;
            shreg  <= sel_word;
            od_oe  <= ~sel_word[WIDTH-1];
            cyc    <= '0;
            bitn   <= '0;
            rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          if (!sample) begin
            cyc <= cyc + 1'b1;
          end else begin
            rx_data <= {rx_data[WIDTH-2:0], line_in};
            shreg   <= shreg << 1;
            if (collide) begin
              err   <= 1'b1;
              gnt   <= '0;
              od_oe <= 1'b0;
              scnt  <= '0;
              state <= SETTLE;
            end else if (bitn == BW'(WIDTH - 1)) begin
              done  <= 1'b1;
              gnt   <= '0;
              od_oe <= 1'b0;
              scnt  <= '0;
              state <= SETTLE;
            end else begin
              bitn  <= bitn + 1'b1;
              cyc   <= '0;
              od_oe <= ~shreg[WIDTH-2];
            end
          end
        end
        SETTLE: begin
          od_oe <= 1'b0;
          gnt   <= '0;
          if (scnt == SW'(SETTLE_CYCLES - 1)) state <= IDLE;
          else                                 scnt  <= scnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pullup_bus_sched.sv
// Bench for pullup_bus_sched: a transaction-level model predicts every output each cycle,
// and directed scenarios pin grant order, timing and sampled data with literal values.
module tb_pullup_bus_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int BC    = 4;
  localparam int SC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data_in = '0;
  logic        ext_pull = 1'b0;
  logic        line_in;
  logic        od_oe;
  logic [3:0]  gnt;
  logic        done;
  logic        err;
  logic [7:0]  rx_data;

  assign line_in = ~od_oe & ~ext_pull;

  pullup_bus_sched #(
    .NREQ(NREQ), .WIDTH(WIDTH), .BIT_CYCLES(BC), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .line_in(line_in),
    .od_oe(od_oe), .gnt(gnt), .done(done), .err(err), .rx_data(rx_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  bit model_ready = 1'b0;

  typedef enum {M_IDLE, M_DRIVE, M_SETTLE} mmode_t;
  mmode_t     mode = M_IDLE;
  int         mrr = 0, start = 0, idle_at = 0;
  logic [7:0] word = '0;
  logic       e_od = 1'b0, e_done = 1'b0, e_err = 1'b0;
  logic [3:0] e_gnt = '0;
  logic [7:0] e_rx = '0;

  int         last_owner = -1, last_grant = 0;
  logic [3:0] prev_gnt = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
    data_in = d;
    req     = r;
  endtask

  // Transaction model: bit position and phase come from elapsed time since the grant.
  always @(posedge clk) begin
    int c, el, w;
    logic line;
    c = cyc_n;
    if (rst) begin
      mode = M_IDLE; mrr = 0;
      e_od = 1'b0; e_gnt = '0; e_done = 1'b0; e_err = 1'b0; e_rx = '0;
    end else begin
      e_done = 1'b0;
      e_err  = 1'b0;
      case (mode)
        M_IDLE: if (req != 0) begin
          w = -1;
          for (int k = 0; k < NREQ; k++)
            if (w < 0 && ((req >> ((mrr + k) % NREQ)) & 4'b1) != 0) w = (mrr + k) % NREQ;
          word  = 8'(data_in >> (w * WIDTH));
          start = c + 1;
          e_gnt = 4'(1 << w);
          e_od  = ~word[7];
          mrr   = (w + 1) % NREQ;
          mode  = M_DRIVE;
        end
        M_DRIVE: begin
          el = c - start;
          if (el % BC == BC - 1) begin
            line = ~e_od & ~ext_pull;
            e_rx = {e_rx[6:0], line};
            if (!e_od && !line) begin
              e_err = 1'b1; e_gnt = '0; e_od = 1'b0; mode = M_SETTLE; idle_at = c + SC;
            end else if (el / BC == WIDTH - 1) begin
              e_done = 1'b1; e_gnt = '0; e_od = 1'b0; mode = M_SETTLE; idle_at = c + SC;
            end else begin
              e_od = ~(((word >> (WIDTH - 2 - el / BC)) & 8'h01) != 0);
            end
          end
        end
        M_SETTLE: if (c == idle_at) mode = M_IDLE;
        default: mode = M_IDLE;
      endcase
    end
    cyc_n++;
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      checkOutput("od_oe", od_oe, e_od);
      checkOutput("gnt", gnt, e_gnt);
      checkOutput("done", done, e_done);
      checkOutput("err", err, e_err);
      checkOutput("rx_data", rx_data, e_rx);
    end
  end

  always @(negedge clk) begin
    if (gnt != 0 && prev_gnt == 0) begin
      for (int k = 0; k < NREQ; k++) if (gnt[k]) last_owner = k;
      last_grant = cyc_n;
    end
    prev_gnt = gnt;
  end

  task automatic wait_done(input int budget, output int when, output bit saw_err, output int od_high);
    when = -1; saw_err = 1'b0; od_high = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin
        when = cyc_n; saw_err = err;
        break;
      end
      if (od_oe) od_high++;
    end
    if (when < 0) begin
      checks++; errors++;
      $display("[TB] FAIL wait_done timeout: got no done/err, want one within %0d cycles", budget);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; req = '0; ext_pull = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, when, odh, prev_done;
    bit se;
    logic [7:0] od_exp;
    od_exp = 8'b01011010;

    // Reset values, then a single 0xA5 transaction from requester 0.
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_od", od_oe, 0);
    checkOutput("rst_gnt", gnt, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rx", rx_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'b0001, 32'h000000A5);
    t0 = cyc_n;
    @(posedge clk);
    #1 checkOutput("t1_gnt", gnt, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin
        repeat (BC) @(posedge clk);
        #1;
      end
      checkOutput("t1_od_bit", od_oe, od_exp[i]);
    end
    wait_done(40, when, se, odh);
    req = '0;
    checkOutput("t1_latency", when - t0, 33);
    checkOutput("t1_err", se, 0);
    checkOutput("t1_rx", rx_data, 8'hA5);

    // All four requesting from reset: round-robin order and settle gap.
    pulse_reset();
    applyStimulus(4'b1111, 32'h44332211);
    prev_done = 0;
    for (int k = 0; k < 4; k++) begin
      wait_done(60, when, se, odh);
      req[last_owner] = 1'b0;
      checkOutput("t2_owner", last_owner, k);
      checkOutput("t2_err", se, 0);
      checkOutput("t2_rx", rx_data, 8'(17 * (k + 1)));
      if (k > 0) checkOutput("t2_gap", (last_grant - prev_done) >= 3, 1);
      prev_done = when;
    end
    req = 4'b0001;
    wait_done(60, when, se, odh);
    req = '0;
    checkOutput("t2_regrant_owner", last_owner, 0);
    checkOutput("t2_regrant_gap", (last_grant - prev_done) >= 3, 1);

    // Collision: 0xFF released everywhere, line pulled low externally during bit 1.
    idle_gap();
    applyStimulus(4'b0001, 32'h000000FF);
    t0 = cyc_n;
    repeat (5) @(posedge clk);
    #1 ext_pull = 1'b1;
    wait_done(20, when, se, odh);
    checkOutput("t3_err_cycle", when - t0, 9);
    checkOutput("t3_err", se, 1);
    checkOutput("t3_done", done, 0);
    checkOutput("t3_rx_low", rx_data[1:0], 2'b10);
    req = '0;
    ext_pull = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t3_settle_od", od_oe, 0);
    end

    // Reset in the 10th drive cycle, then an all-zero word proves IDLE and full pull-low.
    idle_gap();
    applyStimulus(4'b0010, 32'h00005A00);
    t0 = cyc_n;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("t4_od", od_oe, 0);
    checkOutput("t4_gnt", gnt, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_err", err, 0);
    checkOutput("t4_rx", rx_data, 0);
    applyStimulus(4'b0100, 32'h11002233);
    t0 = cyc_n;
    wait_done(45, when, se, odh);
    req = '0;
    checkOutput("t6_grant_latency", last_grant - t0, 1);
    checkOutput("t6_owner", last_owner, 2);
    checkOutput("t6_latency", when - t0, 33);
    checkOutput("t6_od_high", odh, 32);
    checkOutput("t6_rx", rx_data, 8'h00);
    checkOutput("t6_err", se, 0);

    // Requester 0 drops mid-word; its transaction still completes, then requester 2 runs.
    idle_gap();
    applyStimulus(4'b0001, 32'h0081003C);
    t0 = cyc_n;
    repeat (2) @(posedge clk);
    #1 req = 4'b0101;
    repeat (12) @(posedge clk);
    #1 req[0] = 1'b0;
    wait_done(40, when, se, odh);
    checkOutput("t5_latency", when - t0, 33);
    checkOutput("t5_owner", last_owner, 0);
    checkOutput("t5_err", se, 0);
    checkOutput("t5_rx", rx_data, 8'h3C);
    wait_done(45, when, se, odh);
    req = '0;
    checkOutput("t5_next_owner", last_owner, 2);
    checkOutput("t5_next_rx", rx_data, 8'h81);
    idle_gap();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
